// File: rtl/priority_decoder_seq_pkg.sv
// Shared definitions for the registered 2-to-4 priority decoder:
// state encodings and hold/gap counter width.
package priority_decoder_seq_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

endpackage

// File: rtl/priority_decoder_seq_decoder_2to4.sv
// Combinational 2-bit index to one-hot decoder; also usable standalone as a
// reference for the encoder side of the link.
module decoder_2to4 (
  input  logic [1:0] idx,
  output logic [3:0] onehot
);

  always_comb begin
    onehot = 4'b0000;
    onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/priority_decoder_seq.sv
// Registered 2-to-4 decoder: holds the one-hot line for HOLD_CYCLES (or until
// ack), then a GAP_CYCLES guard; requests seen while busy are dropped.
//
// state    | meaning
// ST_IDLE  | waiting for V, D = 0
// ST_DRIVE | D holds one-hot of accepted index, cnt counts down hold
// ST_GAP   | guard gap, D = 0, busy still high
module priority_decoder_seq
  import priority_decoder_seq_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] Y,
  input  logic       V,
  input  logic       ack,
  output logic [3:0] D,
  output logic       busy,
  output logic       done,
  output logic       drop,
  output logic [1:0] last_idx
);

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       d_d;
  logic [3:0]       onehot;
  logic [1:0]       last_d;
  logic             busy_d, done_d, drop_d;

  decoder_2to4 u_dec (
    .idx    (Y),
    .onehot (onehot)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      D        <= 4'b0000;
      busy     <= 1'b0;
      done     <= 1'b0;
      drop     <= 1'b0;
      last_idx <= 2'b00;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      D        <= d_d;
      busy     <= busy_d;
      done     <= done_d;
      drop     <= drop_d;
      last_idx <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    d_d     = D;
    last_d  = last_idx;
    done_d  = 1'b0;
    drop_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (V) begin
          state_d = ST_DRIVE;
          cnt_d   = HOLD_LOAD;
          d_d     = onehot;
          last_d  = Y;
        end
      end
      ST_DRIVE: begin
        drop_d = V;
        // ack and terminal count together still yield a single exit
        if (cnt_q == '0 || ack) begin
          d_d    = 4'b0000;
          done_d = 1'b1;
          if (GAP_CYCLES > 0) begin
            state_d = ST_GAP;
            cnt_d   = GAP_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_GAP: begin
        drop_d = V;
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

endmodule

// File: tb/tb_priority_decoder_seq.sv
// Bench for priority_decoder_seq: default instance plus a HOLD=1/GAP=0
// instance, both compared every cycle against a remaining-cycles model.
module tb_priority_decoder_seq;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] Y = 2'b00;
  logic       V = 1'b0;
  logic       ack = 1'b0;

  logic [3:0] D_a, D_b;
  logic       busy_a, busy_b, done_a, done_b, drop_a, drop_b;
  logic [1:0] last_a, last_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  priority_decoder_seq dut_a (
    .clk(clk), .reset_n(reset_n), .Y(Y), .V(V), .ack(ack),
    .D(D_a), .busy(busy_a), .done(done_a), .drop(drop_a), .last_idx(last_a)
  );

  priority_decoder_seq #(.HOLD_CYCLES(1), .GAP_CYCLES(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .Y(Y), .V(V), .ack(ack),
    .D(D_b), .busy(busy_b), .done(done_b), .drop(drop_b), .last_idx(last_b)
  );

  // model: remaining drive and gap cycles per instance
  int         hold_p[2] = '{4, 1};
  int         gap_p[2]  = '{1, 0};
  int         drive_left[2], gap_left[2];
  logic [3:0] m_d[2];
  logic       m_busy[2], m_done[2], m_drop[2];
  logic [1:0] m_last[2];
  int         done_cnt_a;
  int         drive_len_a, last_drive_len_a;

  task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      drive_left[i] = 0; gap_left[i] = 0;
      m_d[i] = 4'b0; m_busy[i] = 1'b0; m_done[i] = 1'b0; m_drop[i] = 1'b0; m_last[i] = 2'b0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      m_done[i] = 1'b0;
      m_drop[i] = 1'b0;
      if (drive_left[i] > 0) begin
        m_drop[i] = V;
        if (drive_left[i] == 1 || ack) begin
          m_d[i] = 4'b0; m_done[i] = 1'b1;
          drive_left[i] = 0; gap_left[i] = gap_p[i];
        end else begin
          drive_left[i]--;
        end
      end else if (gap_left[i] > 0) begin
        m_drop[i] = V;
        gap_left[i]--;
      end else if (V) begin
        m_d[i] = 4'(1 << Y);
        m_last[i] = Y;
        drive_left[i] = hold_p[i];
      end
      m_busy[i] = (drive_left[i] > 0) || (gap_left[i] > 0);
    end
  endtask

  task automatic compare_all();
    check_val("a.D",    8'(D_a),    8'(m_d[0]));
    check_val("a.busy", 8'(busy_a), 8'(m_busy[0]));
    check_val("a.done", 8'(done_a), 8'(m_done[0]));
    check_val("a.drop", 8'(drop_a), 8'(m_drop[0]));
    check_val("a.last", 8'(last_a), 8'(m_last[0]));
    check_val("b.D",    8'(D_b),    8'(m_d[1]));
    check_val("b.busy", 8'(busy_b), 8'(m_busy[1]));
    check_val("b.done", 8'(done_b), 8'(m_done[1]));
    check_val("b.drop", 8'(drop_b), 8'(m_drop[1]));
    check_val("b.last", 8'(last_b), 8'(m_last[1]));
  endtask

  // inputs are changed on the falling edge, so they are stable at the sampling edge
  task automatic tick(input logic v, input logic [1:0] y, input logic a);
    @(negedge clk);
    V = v; Y = y; ack = a;
    @(posedge clk);
    model_step();
    #1;
    if (D_a != 4'b0) drive_len_a++;
    if (done_a) begin
      done_cnt_a++;
      last_drive_len_a = drive_len_a;
      drive_len_a = 0;
    end
    compare_all();
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20 && (m_busy[0] || m_busy[1]); i++) tick(1'b0, 2'b00, 1'b0);
  endtask

  initial begin
    model_reset();
    done_cnt_a = 0; drive_len_a = 0; last_drive_len_a = 0;
    #12;
    compare_all();
    @(negedge clk);
    reset_n = 1'b1;

    // single request Y=2: D=0100 for 4 cycles, busy 5 cycles
    tick(1'b1, 2'd2, 1'b0);
    for (int i = 0; i < 6; i++) tick(1'b0, 2'd0, 1'b0);
    check_val("single.len", 8'(last_drive_len_a), 8'd4);
    check_val("single.last", 8'(last_a), 8'd2);

    // sweep
    for (int y = 0; y < 4; y++) begin
      tick(1'b1, 2'(y), 1'b0);
      wait_idle();
    end

    // early ack on second drive cycle
    tick(1'b1, 2'd3, 1'b0);
    tick(1'b0, 2'd0, 1'b0);
    done_cnt_a = 0;
    tick(1'b0, 2'd0, 1'b1);
    check_val("ack.len", 8'(last_drive_len_a), 8'd2);
    tick(1'b0, 2'd0, 1'b0);
    tick(1'b0, 2'd0, 1'b0);
    check_val("ack.done_cnt", 8'(done_cnt_a), 8'd1);
    wait_idle();

    // V held high, Y=1
    for (int i = 0; i < 16; i++) tick(1'b1, 2'd1, 1'b0);
    tick(1'b0, 2'd0, 1'b0);
    wait_idle();

    // reset mid-drive
    tick(1'b1, 2'd1, 1'b0);
    tick(1'b0, 2'd0, 1'b0);
    check_val("mid.D_before", 8'(D_a), 8'h02);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    reset_n = 1'b1;
    tick(1'b1, 2'd0, 1'b0);
    check_val("post_rst.D", 8'(D_a), 8'h01);
    wait_idle();

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      tick(($urandom_range(0, 9) < 4), 2'($urandom_range(0, 3)), ($urandom_range(0, 9) < 2));
    end
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
